// File: rtl/axis_packet_checker.sv
// Receive-side checker for 512-bit AXIS test packets: sequence, length, keep and payload checks
// with running statistics. Define CHECKER_FLOW_STATS_EN to build the per-flow packet counters.
module axis_packet_checker #(
  parameter int             AXIS_DATA_WIDTH = 512,
  parameter int             AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int             CNT_WIDTH       = 32,
  parameter int             SEQ_WIDTH       = 64,
  parameter int             MAX_BEATS       = 64,
  parameter logic [7:0]     FLOW_A_ID       = 8'hAA,
  parameter logic [7:0]     FLOW_B_ID       = 8'hBB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready_en,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic                       pkt_done,
  output logic                       pkt_ok,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       byte_count,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic [3:0]                 err_flags,
  output logic [SEQ_WIDTH-1:0]       last_bad_seq,
  output logic [CNT_WIDTH-1:0]       flow_a_count,
  output logic [CNT_WIDTH-1:0]       flow_b_count,
  output logic [CNT_WIDTH-1:0]       flow_other_count
);
  localparam int BW = $clog2(MAX_BEATS) + 1;

  typedef enum logic {S_HEAD, S_BODY} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_idx_q, beat_idx_d;
  logic [SEQ_WIDTH-1:0]   exp_seq_q, exp_seq_d;
  logic [15:0]            hdr_len_q, hdr_len_d;
  logic [3:0]             err_pkt_q, err_pkt_d;
  logic                   pkt_done_q, pkt_done_d;
  logic                   pkt_ok_q, pkt_ok_d;
  logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]   byte_count_q, byte_count_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic [3:0]             err_flags_q, err_flags_d;
  logic [SEQ_WIDTH-1:0]   last_bad_seq_q, last_bad_seq_d;

  logic                   beat, is_head, close;
  logic [3:0]             errs;
  logic [15:0]            cur_len, exp_len;
  logic [BW-1:0]          idx_now, beats;
  logic [SEQ_WIDTH-1:0]   exp_payload;

  assign s_axis_tready = ready_en;
  assign beat          = s_axis_tvalid & ready_en;
  assign is_head       = (state_q == S_HEAD);
  assign close         = beat & s_axis_tlast;

  always_comb begin
    state_d        = state_q;
    beat_idx_d     = beat_idx_q;
    exp_seq_d      = exp_seq_q;
    hdr_len_d      = hdr_len_q;
    err_pkt_d      = err_pkt_q;
    pkt_done_d     = 1'b0;
    pkt_ok_d       = 1'b0;
    pkt_count_d    = pkt_count_q;
    byte_count_d   = byte_count_q;
    err_count_d    = err_count_q;
    err_flags_d    = err_flags_q;
    last_bad_seq_d = last_bad_seq_q;

    // Header beat starts a fresh error set; body beats accumulate onto the packet's bits.
    cur_len     = is_head ? {s_axis_tdata[16*8+:8], s_axis_tdata[17*8+:8]} : hdr_len_q;
    idx_now     = is_head ? '0 : beat_idx_q;
    exp_payload = exp_seq_q + SEQ_WIDTH'(beat_idx_q);
    errs        = is_head ? 4'b0 : err_pkt_q;
    errs[2]     = errs[2] | (s_axis_tkeep != {AXIS_KEEP_WIDTH{1'b1}});
    if (is_head)
      errs[0] = s_axis_tdata[8:0] != exp_seq_q[8:0];
    else
      errs[3] = errs[3] |
                (s_axis_tdata != {{(AXIS_DATA_WIDTH-SEQ_WIDTH){1'b0}}, exp_payload});

    // beat_idx never exceeds MAX_BEATS-1, so beats fits in BW bits without wrapping.
    beats   = idx_now + BW'(1);
    exp_len = 16'(beats) * 16'd64 - 16'd14;

    if (beat) begin
      byte_count_d = byte_count_q + CNT_WIDTH'(64);
      if (s_axis_tlast) begin
        errs[1]     = errs[1] | (cur_len != exp_len);
        pkt_done_d  = 1'b1;
        pkt_ok_d    = (errs == 4'b0);
        pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        err_flags_d = err_flags_q | errs;
        if (errs != 4'b0) begin
          err_count_d    = err_count_q + CNT_WIDTH'(1);
          last_bad_seq_d = exp_seq_q;
        end
        exp_seq_d  = exp_seq_q + SEQ_WIDTH'(1);
        state_d    = S_HEAD;
        beat_idx_d = '0;
        err_pkt_d  = 4'b0;
      end else if (is_head) begin
        hdr_len_d  = cur_len;
        beat_idx_d = BW'(1);
        state_d    = S_BODY;
        err_pkt_d  = errs;
      end else begin
        // Overlong packet: hold the index and keep draining until tlast.
        if (beat_idx_q == BW'(MAX_BEATS-1))
          errs[1] = 1'b1;
        else
          beat_idx_d = beat_idx_q + BW'(1);
        err_pkt_d = errs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HEAD;
      beat_idx_q     <= '0;
      exp_seq_q      <= SEQ_WIDTH'(1);
      hdr_len_q      <= '0;
      err_pkt_q      <= '0;
      pkt_done_q     <= 1'b0;
      pkt_ok_q       <= 1'b0;
      pkt_count_q    <= '0;
      byte_count_q   <= '0;
      err_count_q    <= '0;
      err_flags_q    <= '0;
      last_bad_seq_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_idx_q     <= beat_idx_d;
      exp_seq_q      <= exp_seq_d;
      hdr_len_q      <= hdr_len_d;
      err_pkt_q      <= err_pkt_d;
      pkt_done_q     <= pkt_done_d;
      pkt_ok_q       <= pkt_ok_d;
      pkt_count_q    <= pkt_count_d;
      byte_count_q   <= byte_count_d;
      err_count_q    <= err_count_d;
      err_flags_q    <= err_flags_d;
      last_bad_seq_q <= last_bad_seq_d;
    end
  end

  assign pkt_done     = pkt_done_q;
  assign pkt_ok       = pkt_ok_q;
  assign pkt_count    = pkt_count_q;
  assign byte_count   = byte_count_q;
  assign err_count    = err_count_q;
  assign err_flags    = err_flags_q;
  assign last_bad_seq = last_bad_seq_q;

`ifdef CHECKER_FLOW_STATS_EN
  logic [7:0]           flow_q, flow_d, flow_cur;
  logic [CNT_WIDTH-1:0] flow_a_q, flow_a_d, flow_b_q, flow_b_d, flow_o_q, flow_o_d;

  always_comb begin
    flow_d   = flow_q;
    flow_a_d = flow_a_q;
    flow_b_d = flow_b_q;
    flow_o_d = flow_o_q;
    // Single-beat packets close on their header, so use the live byte there.
    flow_cur = is_head ? s_axis_tdata[35*8+:8] : flow_q;
    if (beat && is_head) flow_d = flow_cur;
    if (close) begin
      if (flow_cur == FLOW_A_ID)      flow_a_d = flow_a_q + CNT_WIDTH'(1);
      else if (flow_cur == FLOW_B_ID) flow_b_d = flow_b_q + CNT_WIDTH'(1);
      else                            flow_o_d = flow_o_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flow_q   <= '0;
      flow_a_q <= '0;
      flow_b_q <= '0;
      flow_o_q <= '0;
    end else begin
      flow_q   <= flow_d;
      flow_a_q <= flow_a_d;
      flow_b_q <= flow_b_d;
      flow_o_q <= flow_o_d;
    end
  end

  assign flow_a_count     = flow_a_q;
  assign flow_b_count     = flow_b_q;
  assign flow_other_count = flow_o_q;
`else
  logic unused_flow_ids;
  assign unused_flow_ids  = ^{FLOW_A_ID, FLOW_B_ID, close};
  assign flow_a_count     = '0;
  assign flow_b_count     = '0;
  assign flow_other_count = '0;
`endif
endmodule

// File: doc/axis_packet_checker.md
Name: axis_packet_checker

Overview:
- Synthesizable receive-side checker for the UDP test-packet stream generated for the panic pipeline. It sits on the panic `m_rx_axis` output, or on any AXIS tap.
- It consumes 512-bit AXI-Stream packets and checks each one:
  - header sequence field, IP length field, tkeep and payload pattern;
  - running packet, byte and error counters;
  - per-flow statistics.
- Intended as the hardware end of the traffic generator for on-FPGA self-test.

Parameters:
- AXIS_DATA_WIDTH, 512, stream data width. Only 512 is supported.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- CNT_WIDTH, 32, width of all statistic counters. Counters wrap modulo 2^CNT_WIDTH.
- SEQ_WIDTH, 64, width of the expected-sequence counter.
- MAX_BEATS, 64, longest legal packet in beats.
- FLOW_A_ID, 8'hAA, first tracked flow id.
- FLOW_B_ID, 8'hBB, second tracked flow id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready_en  in  1  backpressure control; s_axis_tready = ready_en.
- s_axis_tdata  in  AXIS_DATA_WIDTH  stream data.
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted.
- s_axis_tlast  in  1  last beat of packet.
- pkt_done  out  1  one-cycle pulse per checked packet.
- pkt_ok  out  1  valid with pkt_done; 1 = packet passed all checks.
- pkt_count  out  CNT_WIDTH  packets received.
- byte_count  out  CNT_WIDTH  accepted beats × 64.
- err_count  out  CNT_WIDTH  packets with at least one error.
- err_flags  out  4  sticky flags: [0] seq, [1] len, [2] keep, [3] data.
- last_bad_seq  out  SEQ_WIDTH  expected sequence of the most recent failing packet.
- flow_a_count  out  CNT_WIDTH  packets whose header flow id equals FLOW_A_ID.
- flow_b_count  out  CNT_WIDTH  packets whose header flow id equals FLOW_B_ID.
- flow_other_count  out  CNT_WIDTH  packets with any other flow id.

Behaviour:
- Handshake:
  - A beat is accepted only when s_axis_tvalid & s_axis_tready.
  - s_axis_tready = ready_en, combinationally.
  - tdata, tkeep and tlast are ignored when no beat is accepted.
- Reset values:
  - All outputs 0.
  - Internal exp_seq = 1.
  - beat_idx = 0.
  - State = S_HEAD.
  - Per-packet error bits cleared.
- S_HEAD (first accepted beat):
  - Latch hdr_len = {tdata[16*8+:8], tdata[17*8+:8]}.
  - Latch flow = tdata[35*8+:8].
  - Seq error if tdata[8:0] != exp_seq[8:0].
  - Set beat_idx = 1.
  - If tlast, close the packet in the same beat. Otherwise go to S_BODY.
- S_BODY (each accepted beat, index beat_idx):
  - Data error if tdata != zero-extended (beat_idx + exp_seq).
  - beat_idx increments.
  - On tlast, close the packet and return to S_HEAD.
  - If beat_idx reaches MAX_BEATS without tlast:
    - set the length error;
    - stop incrementing beat_idx (saturate);
    - keep consuming beats until tlast.
- Every beat, head and body: keep error if tkeep != all-ones.
- Packet close (tlast beat):
  - beats = beat_idx + 1 (saturating).
  - Length error if hdr_len != beats*64 − 14, computed in 16 bits.
  - One cycle after the tlast handshake:
    - pkt_done = 1 and pkt_ok = no per-packet error;
    - pkt_count increments, plus the matching flow counter;
    - err_count increments at most once per packet;
    - err_flags |= per-packet bits;
    - last_bad_seq = exp_seq if the packet failed.
- exp_seq increments by 1 on every packet close. There is no resync on mismatch.
- byte_count adds 64 on every accepted beat, in the cycle after the beat.
- A new header beat may be accepted in the cycle directly after a tlast beat. Throughput is 1 beat per cycle with no bubbles.
- Reset mid-packet:
  - discards the partial packet with no pkt_done;
  - returns the block to S_HEAD, so the next accepted beat is treated as a header;
  - clears all counters and flags.
- Counter wrap is modulo 2^CNT_WIDTH. exp_seq wraps modulo 2^SEQ_WIDTH.

Optional Feature:
- Macro: CHECKER_FLOW_STATS_EN.
- Defined: the flow id is latched from the header and flow_a_count, flow_b_count and flow_other_count are maintained as described.
- Undefined: no flow register or flow counters exist; the three flow outputs are tied to 0. All other behaviour is unchanged.

Test Plan:
- Three back-to-back 4-beat packets:
  - stimulus: seq 1..3, hdr_len 242, flow 8'hAA/8'hBB/8'hAA, payload = beat_idx + seq, full tkeep, ready_en = 1;
  - response: three pkt_done pulses with pkt_ok = 1, pkt_count = 3, byte_count = 768, flow_a_count = 2, flow_b_count = 1, err_count = 0.
- Packet 2 sent with header seq 3:
  - err_flags[0] = 1, err_count = 1, last_bad_seq = 2;
  - following packets are flagged as data errors, since there is no resync.
- Packet with hdr_len 178 but 4 beats:
  - err_flags[1] = 1, pkt_ok = 0 on that pkt_done, pkt_count still increments.
- tkeep = 64'h00FF... on the last beat:
  - err_flags[2] = 1.
- Body beat 2 corrupted with value 0:
  - err_flags[3] = 1, err_count = 1.
- ready_en toggling randomly 50% and tvalid gaps:
  - counts are identical to the no-backpressure run.
- Reset asserted mid-packet (after beat 2 of 4):
  - no pkt_done, all counters 0;
  - next packet with seq 1 passes.
